sram_req_adapter: RTL and testbench

- Request/response front end that sits directly upstream of a banked single-port SRAM top (clk0/addr0/din0/csb0/web0/dout0 pins, 1-cycle read latency).
- Converts a valid/ready request stream into SRAM pin activity.
- Captures dout0 one cycle after each read and buffers it in a small response FIFO.
- Credit-based flow control guarantees no read data is ever dropped when the consumer stalls.

---
 rtl/sram_req_adapter_pkg.sv | 24 ++
 rtl/sram_req_adapter_if.sv | 36 +++
 rtl/sram_rsp_fifo.sv | 58 +++++
 rtl/sram_req_adapter.sv | 79 +++++++
 tb/tb_sram_req_adapter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_req_adapter_pkg.sv
// sram_req_adapter_pkg
//   Shared constants and helpers for the SRAM request adapter slice.
//   SRAM_RD_LATENCY : edges from SRAM sampling a read to dout0 being valid.
//   req_op_e        : request opcode as carried on req_we.
//   cnt_width()     : bits needed to hold a count of 0..depth.
//   ptr_width()     : bits needed to index depth entries (at least 1).
package sram_req_adapter_pkg;

   localparam int SRAM_RD_LATENCY = 1;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } req_op_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// sram_req_adapter_if
//   Bundles the request channel, response channel and SRAM pin group of the
//   adapter. The slave modport is the adapter's view; the master modport is
//   the view of whoever drives requests, consumes responses and models the
//   SRAM (dout0).
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata
//   SRAM    : csb0, web0, addr0, din0, dout0
interface sram_req_adapter_if #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  csb0;
   logic                  web0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dout0,
      output req_ready, rsp_valid, rsp_rdata, csb0, web0, addr0, din0
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, dout0,
      input  req_ready, rsp_valid, rsp_rdata, csb0, web0, addr0, din0
   );
endinterface

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
//   Small circular response buffer for captured SRAM read data.
//   clk0      : clock
//   rst0      : asynchronous active-high reset (pointers and count only)
//   push      : write push_data at the tail
//   push_data : data to store
//   pop       : drop the head entry (ignored while empty)
//   head_data : entry at the head; meaningless while count == 0
//   count     : number of valid entries, 0..DEPTH
module sram_rsp_fifo
   import sram_req_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 2,
   parameter int DEPTH      = 2
) (
   input  logic                          clk0,
   input  logic                          rst0,
   input  logic                          push,
   input  logic [DATA_WIDTH-1:0]         push_data,
   input  logic                          pop,
   output logic [DATA_WIDTH-1:0]         head_data,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int PW = ptr_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  do_pop;

   // Explicit wrap compare so non-power-of-2 depths index correctly.
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop    = pop && (count != '0);
   assign head_data = mem[rd_ptr];

   // Storage is deliberately left unreset.
   always_ff @(posedge clk0) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= nxt(wr_ptr);
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         if (push && !do_pop)      count <= count + 1'b1;
         else if (!push && do_pop) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter
//   Turns a valid/ready request stream into single-port SRAM pin activity and
//   returns read data through a credit-protected response FIFO.
//   clk0 : clock shared with the SRAM
//   rst0 : asynchronous active-high reset
//   bus  : request channel, response channel and SRAM pins (slave view)
//   SRAM pins are combinational from the request channel, so the SRAM samples
//   a request on the same edge that accepts it. Read data is captured
//   SRAM_RD_LATENCY edges later. A read is only accepted when a FIFO slot is
//   guaranteed for it, counting reads still in flight.
module sram_req_adapter
   import sram_req_adapter_pkg::*;
#(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                clk0,
   input  logic                rst0,
   sram_req_adapter_if.slave   bus
);

   localparam int CW = cnt_width(RSP_DEPTH);

   req_op_e                   op;
   logic                      accept;
   logic                      rd_acc;
   logic                      req_rdy;
   logic                      pop;
   logic                      rsp_vld;
   logic [CW-1:0]             count;
   logic [CW:0]               used;
   logic [SRAM_RD_LATENCY-1:0] rd_q;     // reads accepted, awaiting dout0
   logic                      rd_inflight;
   logic [ADDR_WIDTH-1:0]     addr;
   logic [DATA_WIDTH-1:0]     head;

   assign op     = req_op_e'(bus.req_we);
   assign accept = bus.req_valid && req_rdy;
   assign rd_acc = accept && (op == OP_RD);

   // Every in-flight read already owns a FIFO slot.
   assign used    = (CW+1)'(count) + (CW+1)'($countones(rd_q));
   assign rsp_vld = (count != '0);
   assign pop     = rsp_vld && bus.rsp_ready;
   // A pop this edge frees a slot, so rsp_ready feeds req_ready directly;
   // this keeps back-to-back reads at full rate with a 2-entry FIFO.
   assign req_rdy = !rst0 && ((used < (CW+1)'(RSP_DEPTH)) || pop);

   assign rd_inflight = rd_q[SRAM_RD_LATENCY-1];

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) rd_q <= '0;
      else      rd_q <= SRAM_RD_LATENCY'({rd_q, rd_acc});
   end

   sram_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_fifo (
      .clk0      (clk0),
      .rst0      (rst0),
      .push      (rd_inflight),
      .push_data (bus.dout0),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   assign addr          = bus.req_addr;
   assign bus.addr0     = addr;
   assign bus.din0      = bus.req_wdata;
   assign bus.csb0      = !accept;
   assign bus.web0      = !(accept && (op == OP_WR));
   assign bus.req_ready = req_rdy;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_rdata = head;

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter
//   Directed vector table plus reset and randomized scoreboard sequences for
//   sram_req_adapter, with a behavioural 1-cycle-latency SRAM attached.
module tb_sram_req_adapter;

   localparam int DW    = 2;
   localparam int AW    = 4;
   localparam int DEPTH = 2;
   localparam int NRAND = 1000;

   logic clk0 = 1'b0;
   logic rst0 = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   sram_req_adapter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sram_req_adapter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk0 (clk0),
      .rst0 (rst0),
      .bus  (bus)
   );

   always #5 clk0 = ~clk0;

   // Single-port SRAM model: one access per edge, read data next cycle.
   logic [DW-1:0] sram [16];
   always @(posedge clk0) begin
      if (!bus.csb0) begin
         if (!bus.web0) sram[bus.addr0] <= bus.din0;
         else           bus.dout0       <= sram[bus.addr0];
      end
   end

   typedef struct {
      logic          vld;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic          rr;
      logic          e_rdy;
      logic          e_csb;
      logic          e_web;
      logic          e_rv;
      logic [DW-1:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr,
                               input logic rdy, csb, web, rv,
                               input logic [DW-1:0] rd);
      vec_t t;
      t.vld = v; t.we = we; t.addr = a; t.wd = d; t.rr = rr;
      t.e_rdy = rdy; t.e_csb = csb; t.e_web = web; t.e_rv = rv; t.e_rd = rd;
      return t;
   endfunction

   function automatic logic [DW-1:0] dpat(input int i);
      return DW'(i) ^ DW'(1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic rr);
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.rsp_ready = rr;
   endtask

   // FIFO bound monitor, sampled mid-cycle once inputs have settled.
   always @(negedge clk0) begin
      #3;
      if (!rst0) begin
         n_chk++;
         if ((int'(dut.u_fifo.count) > DEPTH) ||
             (dut.u_fifo.push && int'(dut.u_fifo.count) == DEPTH && !dut.u_fifo.pop)) begin
            n_fail++;
            $display("FAIL fifo_bound: count %0d push %0b pop %0b limit %0d at %0t",
                     dut.u_fifo.count, dut.u_fifo.push, dut.u_fifo.pop, DEPTH, $time);
         end
      end
   end

   logic [DW-1:0] refm [16];
   logic [DW-1:0] expq [$];

   initial begin
      // A: write 3=10, read 3, response 2 edges after accept
      vecs.push_back(mk(1, 1, 4'h3, 2'b10, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h3, 2'b00, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 1, 2'b10));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 0));
      // B: preload 0..7, then streaming reads at full rate
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1, 1, AW'(i), dpat(i), 1, 1, 0, 0, 0, 0));
      for (int c = 0; c < 10; c++)
         vecs.push_back(mk(c < 8, 0, AW'(c), 0, 1, 1, !(c < 8), 1, c >= 2,
                           (c >= 2) ? dpat(c - 2) : DW'(0)));
      // C: stalled consumer, credit limit then same-cycle release
      vecs.push_back(mk(1, 0, 4'h0, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 4'h1, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 4'h2, 0, 0, 0, 1, 1, 1, 2'b01));
      vecs.push_back(mk(1, 0, 4'h2, 0, 0, 0, 1, 1, 1, 2'b01));
      vecs.push_back(mk(1, 0, 4'h2, 0, 1, 1, 0, 1, 1, 2'b01));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 1, 1, 1, 2'b00));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 1, 1, 1, 2'b11));
      vecs.push_back(mk(0, 0, 4'h0, 0, 1, 1, 1, 1, 0, 0));
      // D: write F then read F on the next edge
      vecs.push_back(mk(1, 1, 4'hF, 2'b01, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'hF, 2'b00, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 1, 2'b01));
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 0));

      // Reset state, with a write request presented
      drive(1, 1, 4'h5, 2'b11, 1);
      #1;
      chk("rst req_ready", bus.req_ready, 0);
      chk("rst csb0", bus.csb0, 1);
      chk("rst web0", bus.web0, 1);
      chk("rst rsp_valid", bus.rsp_valid, 0);
      @(negedge clk0);
      rst0 = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].vld, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rr);
         #1;
         chk($sformatf("v%0d req_ready", i), bus.req_ready, vecs[i].e_rdy);
         chk($sformatf("v%0d csb0", i), bus.csb0, vecs[i].e_csb);
         chk($sformatf("v%0d web0", i), bus.web0, vecs[i].e_web);
         chk($sformatf("v%0d rsp_valid", i), bus.rsp_valid, vecs[i].e_rv);
         if (vecs[i].e_rv) chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata, vecs[i].e_rd);
         if (vecs[i].vld) chk($sformatf("v%0d addr0", i), bus.addr0, vecs[i].addr);
         if (vecs[i].vld && vecs[i].we) chk($sformatf("v%0d din0", i), bus.din0, vecs[i].wd);
         @(negedge clk0);
      end

      // Mid-cycle reset with one entry buffered and one read in flight
      drive(1, 0, 4'h2, 0, 0);
      @(negedge clk0);
      drive(1, 0, 4'h7, 0, 0);
      @(negedge clk0);
      drive(1, 0, 4'h0, 0, 1);
      #1;
      chk("pre-rst rsp_valid", bus.rsp_valid, 1);
      chk("pre-rst rsp_rdata", bus.rsp_rdata, 2'b11);
      chk("pre-rst req_ready", bus.req_ready, 1);
      chk("pre-rst csb0", bus.csb0, 0);
      #1 rst0 = 1'b1;
      #1;
      chk("mid-rst rsp_valid", bus.rsp_valid, 0);
      chk("mid-rst req_ready", bus.req_ready, 0);
      chk("mid-rst csb0", bus.csb0, 1);
      chk("mid-rst web0", bus.web0, 1);
      drive(0, 0, 4'h0, 0, 1);
      @(negedge clk0);
      @(negedge clk0);
      rst0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("post-rst%0d rsp_valid", k), bus.rsp_valid, 0);
         chk($sformatf("post-rst%0d req_ready", k), bus.req_ready, 1);
         @(negedge clk0);
      end
      drive(1, 0, 4'h4, 0, 1);
      #1 chk("post-rst read req_ready", bus.req_ready, 1);
      @(negedge clk0);
      drive(0, 0, 4'h0, 0, 1);
      #1 chk("post-rst read edge1 rsp_valid", bus.rsp_valid, 0);
      @(negedge clk0);
      #1;
      chk("post-rst read edge2 rsp_valid", bus.rsp_valid, 1);
      chk("post-rst read rsp_rdata", bus.rsp_rdata, 2'b01);
      @(negedge clk0);
      #1 chk("post-rst read drained", bus.rsp_valid, 0);
      @(negedge clk0);

      // Random mix: first 16 ops initialise every address, then random ops
      begin
         int            acc = 0;
         int            cyc = 0;
         logic          pv  = 1'b0;
         logic          pwe = 1'b0;
         logic [AW-1:0] pa  = '0;
         logic [DW-1:0] pd  = '0;
         logic          rr;
         while (acc < NRAND + 16 && cyc < 20000) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
               pv = 1'b1;
               if (acc < 16) begin
                  pwe = 1'b1;
                  pa  = AW'(acc);
               end else begin
                  pwe = 1'($urandom_range(0, 1));
                  pa  = AW'($urandom_range(0, 15));
               end
               pd = DW'($urandom_range(0, 3));
            end
            rr = ($urandom_range(0, 2) != 0);
            drive(pv, pwe, pa, pd, rr);
            #1;
            if (bus.rsp_valid && rr) begin
               if (expq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL rand unexpected rsp: got %0h required none", bus.rsp_rdata);
               end else begin
                  chk("rand rsp_rdata", bus.rsp_rdata, expq.pop_front());
               end
            end
            if (pv && bus.req_ready) begin
               acc++;
               if (pwe) refm[pa] = pd;
               else     expq.push_back(refm[pa]);
               pv = 1'b0;
            end
            cyc++;
            @(negedge clk0);
         end
         chk("rand ops completed", acc, NRAND + 16);
         drive(0, 0, 4'h0, 0, 1);
         for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.rsp_valid) begin
               if (expq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL drain unexpected rsp: got %0h required none", bus.rsp_rdata);
               end else begin
                  chk("drain rsp_rdata", bus.rsp_rdata, expq.pop_front());
               end
            end
            @(negedge clk0);
         end
         chk("drain lost responses", expq.size(), 0);
         #1 chk("drain rsp_valid", bus.rsp_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
